mem_byte_seq: RTL and testbench



---
 rtl/mem_byte_seq_pkg.sv | 14 +
 rtl/mem_byte_seq.sv | 95 +++++++++
 tb/tb_mem_byte_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_byte_seq_pkg.sv
// Shared definitions for the word-to-byte MEM-stage sequencer.
package mem_byte_seq_pkg;

    localparam int unsigned WORD_LEN_DEFAULT      = 32;
    localparam int unsigned MEM_CELL_SIZE_DEFAULT = 8;
    localparam int unsigned DATA_BASE_DEFAULT     = 1024;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_ACCESS = 2'd1,
        MS_DONE   = 2'd2
    } ms_state_e;

endpackage

// File: rtl/mem_byte_seq.sv
// Performs one word load/store as big-endian byte accesses on a byte-wide
// memory port, freezing the pipeline until the word access completes.
module mem_byte_seq
    import mem_byte_seq_pkg::*;
#(
    parameter int unsigned DATA_BASE     = DATA_BASE_DEFAULT,
    parameter int unsigned WORD_LEN      = WORD_LEN_DEFAULT,
    parameter int unsigned MEM_CELL_SIZE = MEM_CELL_SIZE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     readEn,
    input  logic                     writeEn,
    input  logic [WORD_LEN-1:0]      address,
    input  logic [WORD_LEN-1:0]      dataIn,
    output logic [WORD_LEN-1:0]      dataOut,
    output logic                     freeze,
    output logic [WORD_LEN-1:0]      memAddr,
    output logic [MEM_CELL_SIZE-1:0] memWData,
    output logic                     memWe,
    output logic                     memRe,
    input  logic [MEM_CELL_SIZE-1:0] memRData,
    input  logic                     memAck
);

    localparam int unsigned          CELLS      = WORD_LEN / MEM_CELL_SIZE;
    localparam int unsigned          CNT_W      = $clog2(CELLS);
    localparam logic [CNT_W-1:0]     LAST_CELL  = CNT_W'(CELLS - 1);
    localparam logic [WORD_LEN-1:0]  ALIGN_MASK = ~WORD_LEN'(CELLS - 1);

    ms_state_e           state;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_LEN-1:0] base;
    logic [WORD_LEN-1:0] st_reg;
    logic [WORD_LEN-1:0] rd_reg;
    logic                is_store;

    logic req;
    logic low;
    logic load;

    // A simultaneous read and write request is treated as a store.
    assign req  = readEn | writeEn;
    assign load = readEn & ~writeEn;
    assign low  = (address < WORD_LEN'(DATA_BASE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MS_IDLE;
            cnt      <= '0;
            base     <= '0;
            st_reg   <= '0;
            rd_reg   <= '0;
            is_store <= 1'b0;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (req && !low) begin
                        state    <= MS_ACCESS;
                        cnt      <= '0;
                        base     <= address & ALIGN_MASK;
                        st_reg   <= dataIn;
                        is_store <= writeEn;
                    end
                end
                MS_ACCESS: begin
                    if (memAck) begin
                        cnt <= cnt + 1'b1;
                        if (is_store) begin
                            st_reg <= st_reg << MEM_CELL_SIZE;
                        end else begin
                            rd_reg <= {rd_reg[WORD_LEN-MEM_CELL_SIZE-1:0], memRData};
                        end
                        if (cnt == LAST_CELL) begin
                            state <= MS_DONE;
                        end
                    end
                end
                MS_DONE: state <= MS_IDLE;
                default: state <= MS_IDLE;
            endcase
        end
    end

    // Port outputs decode purely from registered state, so they stay stable
    // across wait cycles and drop to zero as soon as reset is applied.
    assign memAddr  = (state == MS_ACCESS) ? (base + WORD_LEN'(cnt)) : '0;
    assign memWe    = (state == MS_ACCESS) &&  is_store;
    assign memRe    = (state == MS_ACCESS) && !is_store;
    assign memWData = st_reg[WORD_LEN-1 -: MEM_CELL_SIZE];

    assign freeze  = req & ~low & (state != MS_DONE) & ~rst;
    assign dataOut = (load && low) ? '0 : rd_reg;

endmodule

// File: tb/tb_mem_byte_seq.sv
// Scoreboard bench for mem_byte_seq: stimulus queues expected byte accesses and
// word completions; a negedge monitor pops and compares them as the DUT shows them.
module tb_mem_byte_seq;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } byte_t;

    typedef struct {
        int          fc;
        logic [31:0] dout;
    } done_t;

    logic        clk;
    logic        rst;
    logic        readEn;
    logic        writeEn;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        freeze;
    logic [31:0] memAddr;
    logic [7:0]  memWData;
    logic        memWe;
    logic        memRe;
    logic [7:0]  memRData;
    logic        memAck;

    logic [7:0]  mem [0:2047];
    byte_t       byte_q[$];
    done_t       done_q[$];
    int          total = 0;
    int          bad = 0;
    int          fcnt = 0;
    int          stall_used = 0;
    int          stall_budget = 0;
    logic [31:0] stall_addr = 32'h0;

    mem_byte_seq #(.DATA_BASE(1024), .WORD_LEN(32), .MEM_CELL_SIZE(8)) dut (
        .clk(clk), .rst(rst), .readEn(readEn), .writeEn(writeEn),
        .address(address), .dataIn(dataIn), .dataOut(dataOut), .freeze(freeze),
        .memAddr(memAddr), .memWData(memWData), .memWe(memWe), .memRe(memRe),
        .memRData(memRData), .memAck(memAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory with a programmable stall on one address.
    assign memRData = mem[memAddr[10:0]];
    assign memAck   = !((memRe || memWe) && memAddr == stall_addr && stall_used < stall_budget);

    always @(posedge clk) begin
        if ((memRe || memWe) && memAddr == stall_addr && stall_used < stall_budget)
            stall_used <= stall_used + 1;
        if (memWe && memAck)
            mem[memAddr[10:0]] <= memWData;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic we, input logic [31:0] base, input logic [31:0] data);
        for (int k = 0; k < 4; k++) begin
            byte_t b;
            b.we   = we;
            b.addr = base + 32'(k);
            b.data = data[31 - 8*k -: 8];
            byte_q.push_back(b);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge with requests cleared.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] din, input int exp_fc, input logic [31:0] exp_dout);
        done_t d;
        bit    seen;
        push_word(wr, addr & 32'hFFFF_FFFC, din);
        d.fc   = exp_fc;
        d.dout = exp_dout;
        done_q.push_back(d);
        readEn  = rd;
        writeEn = wr;
        address = addr;
        dataIn  = din;
        seen    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!freeze) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL req_timeout: freeze never dropped for address %h", addr);
        end
        @(posedge clk);
        #1;
        readEn  = 1'b0;
        writeEn = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dataOut"}, dataOut, 32'h0);
        chk({tag, "_freeze"}, {31'h0, freeze}, 32'h0);
        chk({tag, "_memWe"}, {31'h0, memWe}, 32'h0);
        chk({tag, "_memRe"}, {31'h0, memRe}, 32'h0);
        chk({tag, "_memAddr"}, memAddr, 32'h0);
        chk({tag, "_memWData"}, {24'h0, memWData}, 32'h0);
    endtask

    // Monitor: byte accesses and word completions against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            fcnt = 0;
        end else begin
            if (memWe || memRe) begin
                if (byte_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_access: we=%b re=%b addr=%h", memWe, memRe, memAddr);
                end else if (memAck) begin
                    byte_t e;
                    e = byte_q.pop_front();
                    chk("byte_we", {31'h0, memWe}, {31'h0, e.we});
                    chk("byte_addr", memAddr, e.addr);
                    if (e.we) chk("byte_wdata", {24'h0, memWData}, {24'h0, e.data});
                end else begin
                    chk("hold_addr", memAddr, byte_q[0].addr);
                    chk("hold_re", {31'h0, memRe}, {31'h0, !byte_q[0].we});
                end
            end
            if (freeze) begin
                fcnt++;
            end else if (fcnt != 0) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: freeze cycles %0d", fcnt);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("freeze_cycles", 32'(fcnt), 32'(d.fc));
                    chk("done_dataOut", dataOut, d.dout);
                end
                fcnt = 0;
            end
        end
    end

    initial begin
        rst = 1'b1; readEn = 1'b0; writeEn = 1'b0; address = '0; dataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;
        #1;
        chk_zero_outputs("post_reset");

        do_req(1'b0, 1'b1, 32'h0406, 32'hDEADBEEF, 5, 32'h0);
        do_req(1'b1, 1'b0, 32'h0404, 32'h0, 5, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        #1;
        chk("load_held", dataOut, 32'hDEADBEEF);

        // Low region: no port activity, no freeze, zero load data in the same cycle.
        readEn = 1'b1; address = 32'h03FC;
        #1;
        chk("low_load_dataOut", dataOut, 32'h0);
        chk("low_load_freeze", {31'h0, freeze}, 32'h0);
        @(negedge clk);
        chk("low_load_memRe", {31'h0, memRe}, 32'h0);
        @(posedge clk);
        #1;
        readEn = 1'b0; writeEn = 1'b1; address = 32'h0; dataIn = 32'h55AA55AA;
        @(negedge clk);
        chk("low_store_freeze", {31'h0, freeze}, 32'h0);
        chk("low_store_memWe", {31'h0, memWe}, 32'h0);
        @(posedge clk);
        #1;
        writeEn = 1'b0;
        #1;
        chk("low_after_held", dataOut, 32'hDEADBEEF);

        do_req(1'b1, 1'b1, 32'h0408, 32'h01020304, 5, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h0408, 32'h0, 5, 32'h01020304);

        stall_addr   = 32'h0405;
        stall_budget = stall_used + 2;
        do_req(1'b1, 1'b0, 32'h0406, 32'h0, 7, 32'hDEADBEEF);

        do_req(1'b0, 1'b1, 32'h0500, 32'h11223344, 5, 32'hDEADBEEF);

        // Reset in the cycle after byte 1 is acknowledged.
        push_word(1'b1, 32'h0500, 32'hCAFEF00D);
        void'(byte_q.pop_back());
        void'(byte_q.pop_back());
        writeEn = 1'b1; address = 32'h0500; dataIn = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_zero_outputs("mid_reset");
        writeEn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("partial_b0", {24'h0, mem[11'h500]}, 32'hCA);
        chk("partial_b1", {24'h0, mem[11'h501]}, 32'hFE);
        chk("partial_b2", {24'h0, mem[11'h502]}, 32'h33);
        chk("partial_b3", {24'h0, mem[11'h503]}, 32'h44);

        do_req(1'b1, 1'b0, 32'h0501, 32'h0, 5, 32'hCAFE3344);
        do_req(1'b1, 1'b0, 32'h0404, 32'h0, 5, 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        #1;
        chk("byte_q_empty", 32'(byte_q.size()), 32'h0);
        chk("done_q_empty", 32'(done_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
